pattern_detector: RTL and testbench
===================================

PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 The block SHALL expose parameter SEQ_W, default 4: pattern length in samples; legal range 2..32.
REQ-002 The block SHALL expose parameter PATTERN, default 4'b1111, width SEQ_W: target sequence, MSB = oldest sample.
REQ-003 The block SHALL expose parameter MASK, default all ones, width SEQ_W: bit 1 = compare, bit 0 = don't-care.
REQ-004 The block SHALL expose parameter DIV, default 25_000_000: clk_50m cycles per sample period; legal range 2..2^26.
REQ-005 The block SHALL expose parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-006 The block SHALL expose parameter CNT_W, default 8: match counter width.
REQ-007 The block SHALL have port clk_50m, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port data_in, input, 1 bit: serial data, asynchronous to clk_50m.
REQ-010 The block SHALL have port clear, input, 1 bit: synchronous clear, active high.
REQ-011 The block SHALL have port indication, output, 1 bit: toggles once per sample period (LED strobe).
REQ-012 The block SHALL have port x, output, 1 bit: level; high while the last evaluated window matches.
REQ-013 The block SHALL have port match_pulse, output, 1 bit: one clk_50m cycle per registered match.
REQ-014 The block SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.

Function
REQ-015 data_in SHALL pass through a 2-flop synchronizer (reset 0); only the synchronized value is sampled.
REQ-016 The divider SHALL count 0..DIV-1 and wrap to 0; sample_en is high for exactly one cycle when the count equals DIV-1.
REQ-017 The first sample_en after reset or clear SHALL occur DIV cycles after release.
REQ-018 indication SHALL toggle on the edge where sample_en is high.
REQ-019 On sample_en, history SHALL shift as hist <= {hist[SEQ_W-2:0], din_sync}.
REQ-020 On sample_en, fill SHALL increment, saturating at SEQ_W.
REQ-021 The match condition SHALL be: fill_next == SEQ_W and ((hist_next ^ PATTERN) & MASK) == 0, where hist_next and fill_next are the post-shift values.
REQ-022 On the sample_en edge, x SHALL load the match condition and hold it until the next sample_en.
REQ-023 On the sample_en edge, match_pulse SHALL load the match condition; it is forced to 0 on every other cycle.
REQ-024 Latency SHALL be 1 clk_50m cycle from sample_en to x/match_pulse, and 3 cycles from data_in to being sampled.
REQ-025 When OVERLAP=0 and a match is registered, fill SHALL be set to 0 on the same edge, so the next match requires SEQ_W fresh samples.
REQ-026 When OVERLAP=1, fill SHALL stay saturated, so consecutive windows may match.
REQ-027 match_cnt SHALL increment on each match_pulse and saturate at 2^CNT_W-1; it SHALL NOT wrap.
REQ-028 When clear=1, the block SHALL zero the divider, hist, fill, x, match_pulse, match_cnt and indication on that edge.
REQ-029 clear SHALL take priority over a simultaneous sample_en: no shift and no pulse occur.
REQ-030 The synchronizer SHALL be unaffected by clear.

Reset
REQ-031 When rst_n is low, the block SHALL immediately set all registers to 0, independent of the clock: synchronizer, divider, hist, fill, indication, x, match_pulse, match_cnt.
REQ-032 Reset asserted mid-period or mid-pattern SHALL discard partial history; after release, detection restarts with fill=0.

Verification (DIV=4, SEQ_W=4 unless stated)
REQ-033 The bench SHALL cover reset mid-operation: pull rst_n low with x=1 and match_cnt=5 -> all outputs 0 before the next clock edge; first sample_en 4 cycles after release.
REQ-034 The bench SHALL cover overlap: OVERLAP=1, PATTERN=1111, data_in=1 for 6 samples -> x rises after sample 4 and stays high through sample 6; 3 match_pulses; match_cnt=3.
REQ-035 The bench SHALL cover non-overlap: OVERLAP=0, same stimulus for 8 samples -> pulses after samples 4 and 8 only; x low after sample 5; match_cnt=2.
REQ-036 The bench SHALL cover masking: PATTERN=1010, MASK=1110, samples 1,0,1,1 then 1,0,1,0 -> match on both windows; 1,1,1,0 -> no match.
REQ-037 The bench SHALL cover saturation: CNT_W=2 with 5 matches -> match_cnt stays 3; pulses continue.
REQ-038 The bench SHALL cover clear collision: clear=1 on the sample_en cycle of a would-be match -> no pulse, match_cnt=0, indication=0, next sample_en 4 cycles later.

Source files
------------

// File: rtl/pattern_detector.sv
// Serial pattern detector: synchronizes data_in, samples it once per DIV-cycle
// period and flags when the last SEQ_W samples match PATTERN under MASK.
module pattern_detector #(
  parameter int               SEQ_W   = 4,
  parameter logic [SEQ_W-1:0] PATTERN = 4'b1111,
  parameter logic [SEQ_W-1:0] MASK    = {SEQ_W{1'b1}},
  parameter int               DIV     = 25_000_000,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic             clear,
  output logic             indication,
  output logic             x,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int DIV_W  = $clog2(DIV);
  localparam int FILL_W = $clog2(SEQ_W + 1);

  logic [1:0]       sync_reg;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [SEQ_W-1:0] hist_reg, hist_next, hist_shift;
  logic [FILL_W-1:0] fill_reg, fill_next, fill_shift;
  logic             ind_reg, ind_next;
  logic             x_reg, x_next;
  logic             pulse_reg, pulse_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sample_en;
  logic             match;

  // Two-flop synchronizer; deliberately outside the reach of clear.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], data_in};
    end
  end

  always_comb begin
    sample_en  = (div_reg == DIV_W'(DIV - 1));
    hist_shift = {hist_reg[SEQ_W-2:0], sync_reg[1]};
    fill_shift = (fill_reg == FILL_W'(SEQ_W)) ? fill_reg : fill_reg + 1'b1;
    match      = (fill_shift == FILL_W'(SEQ_W)) &&
                 (((hist_shift ^ PATTERN) & MASK) == '0);

    div_next   = sample_en ? '0 : div_reg + 1'b1;
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    ind_next   = ind_reg;
    x_next     = x_reg;
    pulse_next = 1'b0;
    cnt_next   = cnt_reg;

    // clear outranks a coincident sample_en: nothing shifts, nothing pulses.
    if (clear) begin
      div_next  = '0;
      hist_next = '0;
      fill_next = '0;
      ind_next  = 1'b0;
      x_next    = 1'b0;
      cnt_next  = '0;
    end else if (sample_en) begin
      hist_next  = hist_shift;
      fill_next  = (match && (OVERLAP == 0)) ? '0 : fill_shift;
      ind_next   = ~ind_reg;
      x_next     = match;
      pulse_next = match;
      if (match && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      div_reg   <= '0;
      hist_reg  <= '0;
      fill_reg  <= '0;
      ind_reg   <= 1'b0;
      x_reg     <= 1'b0;
      pulse_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      div_reg   <= div_next;
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      ind_reg   <= ind_next;
      x_reg     <= x_next;
      pulse_reg <= pulse_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign indication  = ind_reg;
  assign x           = x_reg;
  assign match_pulse = pulse_reg;
  assign match_cnt   = cnt_reg;

endmodule

// File: tb/tb_pattern_detector.sv
// Bench for pattern_detector: four DIV=4 instances (overlap, non-overlap,
// masked, 2-bit counter) checked through a queue-based scoreboard.
module tb_pattern_detector;

  logic       clk = 1'b0;
  logic [3:0] rst_n_v = 4'b0000;
  logic       data_in = 1'b0;
  logic       clear = 1'b0;
  int         sel = 0;

  logic       x_w   [4];
  logic       p_w   [4];
  logic       ind_w [4];
  logic [7:0] cnt_w [4];
  logic [1:0] cnt_sat;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       x;
    logic       p;
    logic [7:0] cnt;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  pattern_detector #(.SEQ_W(4), .PATTERN(4'b1111), .MASK(4'b1111), .DIV(4), .OVERLAP(1), .CNT_W(8)) u_ovl (
    .clk_50m(clk), .rst_n(rst_n_v[0]), .data_in(data_in), .clear(clear),
    .indication(ind_w[0]), .x(x_w[0]), .match_pulse(p_w[0]), .match_cnt(cnt_w[0]));

  pattern_detector #(.SEQ_W(4), .PATTERN(4'b1111), .MASK(4'b1111), .DIV(4), .OVERLAP(0), .CNT_W(8)) u_nov (
    .clk_50m(clk), .rst_n(rst_n_v[1]), .data_in(data_in), .clear(clear),
    .indication(ind_w[1]), .x(x_w[1]), .match_pulse(p_w[1]), .match_cnt(cnt_w[1]));

  pattern_detector #(.SEQ_W(4), .PATTERN(4'b1010), .MASK(4'b1110), .DIV(4), .OVERLAP(1), .CNT_W(8)) u_msk (
    .clk_50m(clk), .rst_n(rst_n_v[2]), .data_in(data_in), .clear(clear),
    .indication(ind_w[2]), .x(x_w[2]), .match_pulse(p_w[2]), .match_cnt(cnt_w[2]));

  pattern_detector #(.SEQ_W(4), .PATTERN(4'b1111), .MASK(4'b1111), .DIV(4), .OVERLAP(1), .CNT_W(2)) u_sat (
    .clk_50m(clk), .rst_n(rst_n_v[3]), .data_in(data_in), .clear(clear),
    .indication(ind_w[3]), .x(x_w[3]), .match_pulse(p_w[3]), .match_cnt(cnt_sat));

  assign cnt_w[3] = {6'd0, cnt_sat};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (inst %0d, t=%0t)", name, act, exp, sel, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One sample period: data for this sample plus the expected registered result.
  task automatic do_sample(input logic b, input logic ex, input logic ep, input int ec);
    data_in = b;
    q.push_back(exp_t'{x: ex, p: ep, cnt: 8'(ec)});
    repeat (4) tick();
  endtask

  task automatic start(input int s);
    tick();
    rst_n_v = 4'b0000;
    tick();
    sel = s;
    rst_n_v[s] = 1'b1;
  endtask

  // Monitor: every indication toggle marks a registered sample; pop and compare.
  logic       prev_ind = 1'b0;
  logic       prev_ok = 1'b0;
  logic       pend = 1'b0;
  logic [7:0] pend_cnt = 8'd0;
  exp_t       e;

  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (rst_n_v[sel]) check("match_cnt", int'(cnt_w[sel]), int'(pend_cnt));
      end
      if (prev_ok && rst_n_v[sel]) begin
        if (ind_w[sel] != prev_ind) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample: got toggle expected none (inst %0d, t=%0t)", sel, $time);
          end else begin
            e = q.pop_front();
            $display("sample inst=%0d x=%0b pulse=%0b cnt=%0d (exp x=%0b pulse=%0b cnt=%0d)",
                     sel, x_w[sel], p_w[sel], cnt_w[sel], e.x, e.p, e.cnt);
            check("x", int'(x_w[sel]), int'(e.x));
            check("match_pulse", int'(p_w[sel]), int'(e.p));
            pend     = 1'b1;
            pend_cnt = e.cnt;
          end
        end else begin
          check("pulse_idle", int'(p_w[sel]), 0);
        end
      end
      prev_ind = ind_w[sel];
      prev_ok  = rst_n_v[sel] && !clear;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and overlapping detection on 1111.
    start(0);
    check("rst_x", int'(x_w[0]), 0);
    check("rst_pulse", int'(p_w[0]), 0);
    check("rst_cnt", int'(cnt_w[0]), 0);
    check("rst_ind", int'(ind_w[0]), 0);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    do_sample(1'b1, 1'b1, 1'b1, 1);
    do_sample(1'b1, 1'b1, 1'b1, 2);
    do_sample(1'b1, 1'b1, 1'b1, 3);
    do_sample(1'b1, 1'b1, 1'b1, 4);
    do_sample(1'b1, 1'b1, 1'b1, 5);

    // Asynchronous reset mid-operation, then restart timing.
    tick();
    check("pre_rst_x", int'(x_w[0]), 1);
    check("pre_rst_cnt", int'(cnt_w[0]), 5);
    rst_n_v[0] = 1'b0;
    #1;
    check("async_rst_x", int'(x_w[0]), 0);
    check("async_rst_pulse", int'(p_w[0]), 0);
    check("async_rst_cnt", int'(cnt_w[0]), 0);
    check("async_rst_ind", int'(ind_w[0]), 0);
    tick();
    data_in = 1'b0;
    q.push_back(exp_t'{x: 1'b0, p: 1'b0, cnt: 8'd0});
    rst_n_v[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("post_rst_ind_early", int'(ind_w[0]), 0);
    end
    tick();
    check("post_rst_ind_first", int'(ind_w[0]), 1);

    // clear on the sample_en cycle of a would-be match.
    start(0);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    data_in = 1'b1;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_pulse", int'(p_w[0]), 0);
    check("clr_x", int'(x_w[0]), 0);
    check("clr_cnt", int'(cnt_w[0]), 0);
    check("clr_ind", int'(ind_w[0]), 0);
    q.push_back(exp_t'{x: 1'b0, p: 1'b0, cnt: 8'd0});
    repeat (3) tick();
    check("clr_ind_early", int'(ind_w[0]), 0);
    tick();
    check("clr_ind_next", int'(ind_w[0]), 1);

    // Non-overlapping: second match needs four fresh samples.
    start(1);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    do_sample(1'b1, 1'b1, 1'b1, 1);
    do_sample(1'b1, 1'b0, 1'b0, 1);
    do_sample(1'b1, 1'b0, 1'b0, 1);
    do_sample(1'b1, 1'b0, 1'b0, 1);
    do_sample(1'b1, 1'b1, 1'b1, 2);

    // Masked compare: PATTERN 1010, LSB don't-care.
    start(2);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    do_sample(1'b0, 1'b0, 1'b0, 0);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    do_sample(1'b1, 1'b1, 1'b1, 1);
    do_sample(1'b1, 1'b0, 1'b0, 1);
    do_sample(1'b0, 1'b0, 1'b0, 1);
    do_sample(1'b1, 1'b0, 1'b0, 1);
    do_sample(1'b0, 1'b1, 1'b1, 2);
    start(2);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    do_sample(1'b0, 1'b0, 1'b0, 0);

    // 2-bit counter saturates at 3 while pulses keep coming.
    start(3);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    do_sample(1'b1, 1'b0, 1'b0, 0);
    do_sample(1'b1, 1'b1, 1'b1, 1);
    do_sample(1'b1, 1'b1, 1'b1, 2);
    do_sample(1'b1, 1'b1, 1'b1, 3);
    do_sample(1'b1, 1'b1, 1'b1, 3);
    do_sample(1'b1, 1'b1, 1'b1, 3);

    repeat (3) tick();
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
